esfa_rank_scan: RTL and testbench

- Sequential front end for the ESFA rank operation: holds a small table of array-handle entries and, per query, scans the table one entry per cycle.
- Returns the rank of the first entry whose metadata matches the queried handle.
- Sits upstream of the rank result consumers, turning single-shot combinational rank evaluation into a handshaked, table-driven lookup.

---
 rtl/esfa_pkg.sv | 20 ++
 rtl/esfa_rank_match.sv | 16 +
 rtl/esfa_rank_scan.sv | 90 +++++++++
 tb/tb_esfa_rank_scan.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/esfa_pkg.sv
// esfa_pkg: shared types and constants for the ESFA rank scan blocks
package esfa_pkg;

    localparam int DATA_W   = 8;
    localparam int MAX_META = 7;

    typedef struct packed {
        logic              arr_def;
        logic              is_metadata;
        logic [DATA_W-1:0] metadata;
        logic [DATA_W-1:0] rank;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

endpackage

// File: rtl/esfa_rank_match.sv
// esfa_rank_match: combinational predicate telling whether one table entry matches a handle
module esfa_rank_match
    import esfa_pkg::*;
#(
    parameter int MAX_META = esfa_pkg::MAX_META
) (
    input  entry_t            entry,
    input  logic [DATA_W-1:0] handle,
    output logic              match
);

    // Metadata above MAX_META is out of scope and can never match, even if equal to the handle
    assign match = entry.arr_def && entry.is_metadata &&
                   (32'(entry.metadata) <= MAX_META) && (entry.metadata == handle);

endmodule

// File: rtl/esfa_rank_scan.sv
// esfa_rank_scan: handshaked lookup scanning a small entry table one entry per cycle
module esfa_rank_scan
    import esfa_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int MAX_META = esfa_pkg::MAX_META
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_arrDef,
    input  logic              wr_isMetadata,
    input  logic [DATA_W-1:0] wr_metadata,
    input  logic [DATA_W-1:0] wr_rank,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [DATA_W-1:0] q_handle,
    output logic              r_valid,
    input  logic              r_ready,
    output logic              r_found,
    output logic [DATA_W-1:0] r_rank,
    output logic [ADDR_W-1:0] r_index
);

    entry_t            table_q [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] handle_q;
    logic              hit;
    logic              last;

    // The scan reads the pre-edge table, so a same-cycle write to the entry under the pointer is not seen
    esfa_rank_match #(.MAX_META(MAX_META)) u_match (
        .entry  (table_q[ptr]),
        .handle (handle_q),
        .match  (hit)
    );

    assign last = ptr == ADDR_W'(DEPTH - 1);

    // Table writes are accepted in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
        end else if (wr_en) begin
            table_q[wr_addr] <= '{wr_arrDef, wr_isMetadata, wr_metadata, wr_rank};
        end
    end

    // Query FSM: capture handle, walk the table lowest index first, hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            q_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_found  <= 1'b0;
            r_rank   <= '0;
            r_index  <= '0;
            handle_q <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                IDLE: if (q_valid) begin
                    handle_q <= q_handle;
                    ptr      <= '0;
                    q_ready  <= 1'b0;
                    state    <= SCAN;
                end
                SCAN: if (hit || last) begin
                    r_found <= hit;
                    r_rank  <= hit ? table_q[ptr].rank : '0;
                    r_index <= hit ? ptr : '0;
                    r_valid <= 1'b1;
                    state   <= RESP;
                end else begin
                    ptr <= ptr + 1'b1;
                end
                RESP: if (r_ready) begin
                    r_valid <= 1'b0;
                    q_ready <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_esfa_rank_scan.sv
// tb_esfa_rank_scan: scoreboard bench for the table-driven rank lookup
module tb_esfa_rank_scan;

    typedef struct {
        logic       found;
        logic [7:0] rank;
        logic [2:0] idx;
        int         lat;
    } exp_t;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       wr_en = 0;
    logic [2:0] wr_addr = 0;
    logic       wr_arrDef = 0;
    logic       wr_isMetadata = 0;
    logic [7:0] wr_metadata = 0;
    logic [7:0] wr_rank = 0;
    logic       q_valid = 0;
    logic       q_ready;
    logic [7:0] q_handle = 0;
    logic       r_valid;
    logic       r_ready = 1;
    logic       r_found;
    logic [7:0] r_rank;
    logic [2:0] r_index;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   t0 = 0;
    logic prev_rv = 0;

    esfa_rank_scan dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_arrDef(wr_arrDef), .wr_isMetadata(wr_isMetadata),
        .wr_metadata(wr_metadata), .wr_rank(wr_rank),
        .q_valid(q_valid), .q_ready(q_ready), .q_handle(q_handle),
        .r_valid(r_valid), .r_ready(r_ready), .r_found(r_found),
        .r_rank(r_rank), .r_index(r_index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: measures accept-to-valid latency and pops the scoreboard on each handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv = 0;
        end else begin
            if (q_valid && q_ready) t0 = cyc;
            if (r_valid && !prev_rv) begin
                if (sb.size() == 0) chk("unexpected_result", 1, 0);
                else chk("latency", cyc - t0, sb[0].lat);
            end
            if (r_valid && r_ready && sb.size() != 0) begin
                chk("r_found", r_found, sb[0].found);
                chk("r_rank", r_rank, sb[0].rank);
                chk("r_index", r_index, sb[0].idx);
                void'(sb.pop_front());
            end
            prev_rv = r_valid;
        end
    end

    task automatic wr(input logic [2:0] a, input logic ad, input logic im,
                      input logic [7:0] m, input logic [7:0] rk);
        wr_en = 1; wr_addr = a; wr_arrDef = ad; wr_isMetadata = im;
        wr_metadata = m; wr_rank = rk;
        @(posedge clk); #1;
        wr_en = 0;
    endtask

    task automatic query(input logic [7:0] h, input logic f, input logic [7:0] rk,
                         input logic [2:0] ix, input int lat);
        sb.push_back('{f, rk, ix, lat});
        q_valid = 1; q_handle = h;
        @(posedge clk); #1;
        q_valid = 0;
    endtask

    task automatic drain;
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q_ready", q_ready, 1);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_found", r_found, 0);
        chk("rst_r_rank", r_rank, 0);
        chk("rst_r_index", r_index, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        query(8'd3, 0, 8'h00, 3'd0, 9);
        drain();

        wr(3'd5, 1, 1, 8'd3, 8'h2A);
        query(8'd3, 1, 8'h2A, 3'd5, 7);
        drain();

        wr(3'd2, 1, 1, 8'd4, 8'h11);
        wr(3'd6, 1, 1, 8'd4, 8'h22);
        query(8'd4, 1, 8'h11, 3'd2, 4);
        drain();

        wr(3'd1, 1, 1, 8'd9, 8'h33);
        query(8'd9, 0, 8'h00, 3'd0, 9);
        drain();

        wr(3'd3, 1, 0, 8'd5, 8'h44);
        wr(3'd4, 0, 1, 8'd5, 8'h55);
        query(8'd5, 0, 8'h00, 3'd0, 9);
        drain();

        // Back-pressure: result held, second query ignored
        r_ready = 0;
        query(8'd3, 1, 8'h2A, 3'd5, 7);
        for (int i = 0; i < 20 && !r_valid; i++) begin @(posedge clk); #1; end
        chk("hold_reached", r_valid, 1);
        q_valid = 1; q_handle = 8'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_r_valid", r_valid, 1);
            chk("hold_q_ready", q_ready, 0);
            chk("hold_r_rank", r_rank, 8'h2A);
            chk("hold_r_index", r_index, 5);
        end
        q_valid = 0;
        r_ready = 1;
        drain();
        chk("back_idle_q_ready", q_ready, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("no_second_result", r_valid, 0);
        chk("idle_hold_r_rank", r_rank, 8'h2A);

        // Write to a higher index during the scan is seen when the pointer gets there
        query(8'd6, 1, 8'h77, 3'd7, 9);
        wr(3'd7, 1, 1, 8'd6, 8'h77);
        drain();

        // Reset mid-scan at pointer 3 abandons the query
        q_valid = 1; q_handle = 8'd3;
        @(posedge clk); #1;
        q_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("midrst_r_valid", r_valid, 0);
        chk("midrst_q_ready", q_ready, 1);
        chk("midrst_r_rank", r_rank, 0);
        chk("midrst_r_index", r_index, 0);
        chk("midrst_r_found", r_found, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_hold_r_valid", r_valid, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        query(8'd3, 0, 8'h00, 3'd0, 9);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
